// File: rtl/poly_result_window_if.sv
// Result bus between the evaluator and the sliding-window stage.
// The master drives samples in and reads the window statistics back.
interface poly_result_window_if #(
   parameter int unsigned DW         = 19,
   parameter int unsigned LOG2_DEPTH = 3
);
   logic                            in_valid;
   logic signed [DW-1:0]            in_data;
   logic signed [DW+LOG2_DEPTH-1:0] sum_out;
   logic signed [DW-1:0]            avg_out;
   logic signed [DW-1:0]            min_out;
   logic signed [DW-1:0]            max_out;
   logic                            out_valid;
   logic [LOG2_DEPTH:0]             fill_cnt;

   modport master (
      output in_valid, in_data,
      input  sum_out, avg_out, min_out, max_out, out_valid, fill_cnt
   );

   modport slave (
      input  in_valid, in_data,
      output sum_out, avg_out, min_out, max_out, out_valid, fill_cnt
   );
endinterface

// File: rtl/poly_result_window.sv
// Sliding-window sum/average over the last DEPTH polynomial results,
// plus running min/max since the last reset or clear.
module poly_result_window #(
   parameter int unsigned DW         = 19,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned LOG2_DEPTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   poly_result_window_if.slave  bus
);
   localparam int unsigned SW = DW + LOG2_DEPTH;
   localparam int unsigned FW = LOG2_DEPTH + 1;

   logic signed [DW-1:0]    mem [DEPTH];
   logic [LOG2_DEPTH-1:0]   wr_ptr;
   logic [FW-1:0]           fill_cnt;
   logic signed [SW-1:0]    sum;
   logic signed [DW-1:0]    avg;
   logic signed [DW-1:0]    min_v;
   logic signed [DW-1:0]    max_v;
   logic                    out_valid;

   logic                    flush_c;
   logic                    accept_c;
   logic                    full_c;
   logic signed [DW-1:0]    oldest_c;
   logic signed [SW-1:0]    sum_nxt_c;
   logic [FW-1:0]           fill_nxt_c;

   // Retire the oldest entry only once the window has wrapped
   always_comb begin
      flush_c    = rst | clear;
      accept_c   = bus.in_valid & ~flush_c;
      full_c     = (fill_cnt == FW'(DEPTH));
      oldest_c   = full_c ? mem[wr_ptr] : '0;
      sum_nxt_c  = sum + SW'(bus.in_data) - SW'(oldest_c);
      fill_nxt_c = full_c ? fill_cnt : fill_cnt + FW'(1);
   end

   // Sample storage is never reset; fill_cnt alone marks valid entries
   always_ff @(posedge clk) begin
      if (accept_c) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (flush_c) begin
         wr_ptr    <= '0;
         fill_cnt  <= '0;
         sum       <= '0;
         avg       <= '0;
         min_v     <= '0;
         max_v     <= '0;
         out_valid <= 1'b0;
      end else if (accept_c) begin
         wr_ptr    <= wr_ptr + LOG2_DEPTH'(1);
         fill_cnt  <= fill_nxt_c;
         sum       <= sum_nxt_c;
         avg       <= DW'(sum_nxt_c >>> LOG2_DEPTH);
         out_valid <= (fill_nxt_c == FW'(DEPTH));
         if (fill_cnt == '0) begin
            min_v <= bus.in_data;
            max_v <= bus.in_data;
         end else begin
            if (bus.in_data < min_v) min_v <= bus.in_data;
            if (bus.in_data > max_v) max_v <= bus.in_data;
         end
      end else begin
         out_valid <= 1'b0;
      end
   end

   assign bus.sum_out   = sum;
   assign bus.avg_out   = avg;
   assign bus.min_out   = min_v;
   assign bus.max_out   = max_v;
   assign bus.out_valid = out_valid;
   assign bus.fill_cnt  = fill_cnt;
endmodule

// File: tb/tb_poly_result_window.sv
// Directed + random bench for poly_result_window; a reference window model
// queues expected statistics per step and checks them one cycle later.
module tb_poly_result_window;
   localparam int unsigned DW         = 19;
   localparam int unsigned DEPTH      = 8;
   localparam int unsigned LOG2_DEPTH = 3;

   typedef struct {
      int sum;
      int avg;
      int mn;
      int mx;
      int ov;
      int fill;
   } exp_t;

   logic clk;
   logic rst;
   logic clear;
   int   total;
   int   bad;
   int   win[$];
   exp_t m;
   exp_t q[$];

   poly_result_window_if #(.DW(DW), .LOG2_DEPTH(LOG2_DEPTH)) bus ();

   poly_result_window #(.DW(DW), .DEPTH(DEPTH), .LOG2_DEPTH(LOG2_DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model: keeps the literal last DEPTH samples and re-sums them
   task automatic model(input logic v, input int d, input logic c, input logic r);
      if (r || c) begin
         win.delete();
         m = '{0, 0, 0, 0, 0, 0};
      end else if (v) begin
         if (win.size() == 0) begin
            m.mn = d;
            m.mx = d;
         end else begin
            if (d < m.mn) m.mn = d;
            if (d > m.mx) m.mx = d;
         end
         win.push_back(d);
         if (win.size() > DEPTH) void'(win.pop_front());
         m.sum = 0;
         foreach (win[i]) m.sum += win[i];
         m.avg  = m.sum >>> LOG2_DEPTH;
         m.fill = win.size();
         m.ov   = (m.fill == DEPTH) ? 1 : 0;
      end else begin
         m.ov = 0;
      end
   endtask

   task automatic step(input logic v, input int d, input logic c, input logic r);
      exp_t e;
      @(negedge clk);
      bus.in_valid = v;
      bus.in_data  = DW'(d);
      clear        = c;
      rst          = r;
      model(v, d, c, r);
      q.push_back(m);
      @(posedge clk);
      #1;
      e = q.pop_front();
      check("sum",       $signed(bus.sum_out), e.sum);
      check("avg",       $signed(bus.avg_out), e.avg);
      check("min",       $signed(bus.min_out), e.mn);
      check("max",       $signed(bus.max_out), e.mx);
      check("out_valid", {31'b0, bus.out_valid}, e.ov);
      check("fill_cnt",  {28'b0, bus.fill_cnt}, e.fill);
   endtask

   initial begin
      int d;
      total        = 0;
      bad          = 0;
      rst          = 1'b1;
      clear        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      m            = '{0, 0, 0, 0, 0, 0};

      // Reset dominates a concurrent valid sample
      step(1, 5, 0, 1);
      step(1, 5, 0, 1);
      check("reset_sum_const", $signed(bus.sum_out), 0);

      // Fill with 3s, then slide in -1s
      for (int i = 0; i < 8; i++) step(1, 3, 0, 0);
      check("fill_sum24", $signed(bus.sum_out), 24);
      step(1, -1, 0, 0);
      check("slide_sum20", $signed(bus.sum_out), 20);
      for (int i = 0; i < 7; i++) step(1, -1, 0, 0);
      check("slide_sum_m8", $signed(bus.sum_out), -8);
      check("slide_avg_m1", $signed(bus.avg_out), -1);

      // Full-scale extremes must not wrap
      for (int i = 0; i < 8; i++) step(1, 262143, 0, 0);
      check("max_sum", $signed(bus.sum_out), 2097144);
      for (int i = 0; i < 8; i++) step(1, -262144, 0, 0);
      check("min_sum", $signed(bus.sum_out), -2097152);
      check("min_avg", $signed(bus.avg_out), -262144);

      // Sparse partial window with idle bubbles
      step(0, 0, 1, 0);
      step(1, 0, 0, 0);  step(0, 9, 0, 0);
      step(1, -1, 0, 0); step(0, 9, 0, 0);
      step(1, -2, 0, 0); step(0, 9, 0, 0);
      step(1, 3, 0, 0);  step(0, 9, 0, 0); step(0, 9, 0, 0);
      check("partial_fill4", {28'b0, bus.fill_cnt}, 4);
      check("partial_min", $signed(bus.min_out), -2);

      // Clear beats a valid sample on a full window
      for (int i = 0; i < 8; i++) step(1, 100 + i, 0, 0);
      step(1, 7, 1, 0);
      check("clear_fill0", {28'b0, bus.fill_cnt}, 0);
      step(1, 7, 0, 0);
      check("after_clear_sum7", $signed(bus.sum_out), 7);

      // Random traffic with bubbles and occasional clears
      for (int i = 0; i < 200; i++) begin
         d = int'($urandom_range(0, 524287)) - 262144;
         step($urandom_range(0, 3) != 0, d, $urandom_range(0, 40) == 0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/poly_result_window.md
Name: poly_result_window

Overview:
Downstream stage for the 19-bit signed polynomial result R produced by the evaluator block. It takes one result per valid cycle and keeps a sliding-window sum and average over the last DEPTH results. It also tracks the running minimum and maximum since the last clear. Its outputs feed the board display/readout logic.

Parameters:
DW, 19, width of incoming signed result (matches evaluator R).
DEPTH, 8, sliding-window length in samples; must be a power of 2, minimum 2.
LOG2_DEPTH, 3, log2(DEPTH); sets sum width and average shift.

Ports:
CLK  input  1  single system clock; all state updates on the rising edge.
RST  input  1  synchronous, active-high reset.
CLEAR  input  1  synchronous window/statistics flush; same effect as RST on all state.
IN_VALID  input  1  IN_DATA is a new result this cycle.
IN_DATA  input  DW  signed result sample (evaluator R).
SUM_OUT  output  DW+LOG2_DEPTH  signed sum of the last DEPTH accepted samples.
AVG_OUT  output  DW  signed SUM_OUT arithmetic-shifted right by LOG2_DEPTH (floor toward -inf).
MIN_OUT  output  DW  signed minimum accepted since reset/clear.
MAX_OUT  output  DW  signed maximum accepted since reset/clear.
OUT_VALID  output  1  one-cycle pulse: window full and stats updated by the sample accepted last cycle.
FILL_CNT  output  LOG2_DEPTH+1  number of valid entries in window, saturates at DEPTH.

Behaviour:
- Reset (RST=1 at edge): wr_ptr=0, FILL_CNT=0, internal sum=0, SUM_OUT=0, AVG_OUT=0, MIN_OUT=0, MAX_OUT=0, OUT_VALID=0. Buffer RAM contents are not cleared; validity is tracked by FILL_CNT only.
- CLEAR has identical effect to RST. RST/CLEAR beat IN_VALID in the same cycle; that sample is dropped.
- Storage: circular buffer of DEPTH x DW, indexed by wr_ptr.
- On accept (IN_VALID=1, no RST/CLEAR):
  - Oldest = buf[wr_ptr] if FILL_CNT==DEPTH, else 0.
  - buf[wr_ptr] <= IN_DATA. wr_ptr <= wr_ptr+1 mod DEPTH (natural wrap).
  - sum <= sum + sext(IN_DATA) - sext(oldest), computed at full DW+LOG2_DEPTH width. No overflow is possible; no saturation logic.
  - FILL_CNT <= min(FILL_CNT+1, DEPTH).
  - First sample after reset/clear (FILL_CNT==0) loads both MIN_OUT and MAX_OUT. Later samples update them by signed compare.
- Latency: one cycle. SUM_OUT, AVG_OUT, MIN_OUT, MAX_OUT, FILL_CNT are registered and reflect the sample accepted on the previous edge.
- OUT_VALID is 1 in the cycle after an accept whose updated FILL_CNT==DEPTH, and 0 otherwise. IN_VALID bubbles give OUT_VALID=0 while outputs hold their values.
- With IN_VALID=0, all state holds.
- Back-to-back IN_VALID is sustained at full rate. There is no backpressure; every valid sample is accepted.
- While FILL_CNT<DEPTH, SUM_OUT is the partial sum and AVG_OUT is still SUM_OUT>>>LOG2_DEPTH (not divided by fill count).

Test Plan:
1. RST high 2 cycles, IN_VALID=1, IN_DATA=5 -> all outputs 0, FILL_CNT=0. Sample not stored.
2. 8 consecutive samples of 3 -> OUT_VALID first 1 one cycle after the 8th accept. SUM_OUT=24, AVG_OUT=3, FILL_CNT=8, MIN=MAX=3.
3. Then 8 samples of -1 -> after 1st: SUM=20. After 8th: SUM=-8, AVG=-1, MIN=-1, MAX=3, OUT_VALID pulsed on each.
4. 8 samples of 262143 -> SUM=2097144. Then 8 of -262144 -> SUM=-2097152, AVG=-262144, no wrap.
5. Sequence 0,-1,-2,3 with idle cycles between samples, after clear -> FILL_CNT=4, SUM=0, MIN=-2, MAX=3, OUT_VALID never 1. Outputs hold during idle cycles.
6. Window full; CLEAR and IN_VALID (data 7) in same cycle -> next cycle all outputs 0, FILL_CNT=0. A following sample 7 gives SUM=7, MIN=MAX=7.
